// File: rtl/alu_scan_display_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_scan_display_if : operand/result bus and 7-segment display pins  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface alu_scan_display_if #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 4
);
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [2:0]        sel;
  logic              start;
  logic [WIDTH-1:0]  result;
  logic [3:0]        flags;
  logic              done;
  logic [DIGITS-1:0] an;
  logic [6:0]        seg;

  modport master (
    output a, b, sel, start,
    input  result, flags, done, an, seg
  );

  modport slave (
    input  a, b, sel, start,
    output result, flags, done, an, seg
  );
endinterface
`default_nettype wire

// File: rtl/alu_scan_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_scan_display : registered ALU with multiplexed hex 7-seg output  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_scan_display #(
  parameter int WIDTH    = 4,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_scan_display_if.slave    bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  logic [WIDTH-1:0]    result_q, result_d;
  logic [3:0]          flags_q, flags_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  logic [WIDTH:0]      sum;
  logic [WIDTH-1:0]    diff;
  logic [WIDTH-1:0]    alu_res;
  logic                alu_c, alu_v;
  logic                wrap;
  logic [4*DIGITS-1:0] disp;
  logic [3:0]          nibble;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    sum     = {1'b0, bus.a} + {1'b0, bus.b};
    diff    = bus.a - bus.b;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.sel)
      3'b000: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      3'b001: begin
        alu_res = diff;
        alu_c   = (bus.a >= bus.b);
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      3'b010: alu_res = bus.a & bus.b;
      3'b011: alu_res = bus.a | bus.b;
      3'b100: alu_res = bus.a ^ bus.b;
      3'b101: alu_res = ~bus.a;
      3'b110: begin
        alu_res = {bus.a[WIDTH-2:0], 1'b0};
        alu_c   = bus.a[WIDTH-1];
      end
      default: begin
        alu_res = {1'b0, bus.a[WIDTH-1:1]};
        alu_c   = bus.a[0];
      end
    endcase
  end

  generate
    if (WIDTH >= 4*DIGITS) begin : g_trunc
      assign disp = result_d[4*DIGITS-1:0];
    end else begin : g_zext
      assign disp = {{(4*DIGITS-WIDTH){1'b0}}, result_d};
    end
  endgenerate

  // seg/an are decoded from next-state values so a new result and a new
  // digit index both show up on the very edge that produces them.
  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = bus.start;
    if (bus.start) begin
      result_d = alu_res;
      flags_d  = {alu_v, alu_res[WIDTH-1], (alu_res == '0), alu_c};
    end
    wrap  = (cnt_q == CNT_MAX);
    cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end
    an_d   = ~(DIGITS'(1) << idx_d);
    nibble = disp[{idx_d, 2'b00} +: 4];
    seg_d  = hex7(nibble);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      an_q     <= ~DIGITS'(1);
      seg_q    <= 7'b1000000;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign bus.result = result_q;
  assign bus.flags  = flags_q;
  assign bus.done   = done_q;
  assign bus.an     = an_q;
  assign bus.seg    = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_scan_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_scan_display : scoreboard bench for alu_scan_display          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alu_scan_display;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int SD = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic [3:0] cur_res;

  alu_scan_display_if #(.WIDTH(W), .DIGITS(D)) bus ();

  alu_scan_display #(.WIDTH(W), .DIGITS(D), .SCAN_DIV(SD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Returns {V,N,Z,C,result} computed with plain integer arithmetic.
  function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] sel);
    int ia, ib, sa, sb, s, r;
    logic c, v;
    ia = int'(a);
    ib = int'(b);
    sa = (ia > 7) ? ia - 16 : ia;
    sb = (ib > 7) ? ib - 16 : ib;
    c  = 1'b0;
    v  = 1'b0;
    case (sel)
      3'd0: begin r = ia + ib; c = (r > 15); s = sa + sb; v = (s > 7) || (s < -8); end
      3'd1: begin r = ia - ib; c = (ia >= ib); s = sa - sb; v = (s > 7) || (s < -8); end
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: r = ia ^ ib;
      3'd5: r = 15 - ia;
      3'd6: begin r = ia * 2; c = (ia >= 8); end
      default: begin r = ia / 2; c = (ia % 2 == 1); end
    endcase
    r = r & 15;
    return {v, (r >= 8), (r == 0), c, 4'(r)};
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  task automatic drive(input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] sel, input logic [7:0] exp_v);
    bus.a     = a;
    bus.b     = b;
    bus.sel   = sel;
    bus.start = 1'b1;
    exp_q.push_back(exp_v);
  endtask

  task automatic test_reset;
    bus.start = 1'b1;
    bus.a     = 4'hF;
    bus.b     = 4'h1;
    bus.sel   = 3'd0;
    #3 rst_n = 1'b0;
    #1;
    total++; if (bus.result !== 4'h0) begin bad++; $display("FAIL reset_result: got %h want 0", bus.result); end
    total++; if (bus.flags !== 4'h0) begin bad++; $display("FAIL reset_flags: got %b want 0000", bus.flags); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    total++; if (bus.an !== 4'b1110) begin bad++; $display("FAIL reset_an: got %b want 1110", bus.an); end
    total++; if (bus.seg !== 7'b1000000) begin bad++; $display("FAIL reset_seg: got %b want 1000000", bus.seg); end
    @(posedge clk); #1;
    total++;
    if (bus.result !== 4'h0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL reset_start_ignored: got result=%h done=%b want 0/0", bus.result, bus.done);
    end
    bus.start = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.done !== 1'b0 || bus.result !== 4'h0) begin
      bad++; $display("FAIL idle_after_reset: got done=%b result=%h want 0/0", bus.done, bus.result);
    end
  endtask

  task automatic test_arith;
    logic [3:0] ta [9];
    logic [3:0] tb_v [9];
    logic [2:0] ts [9];
    logic [7:0] te [9];
    logic [7:0] e;
    ta   = '{4'h9, 4'h3, 4'h2, 4'hA, 4'h5, 4'h0, 4'hC, 4'hC, 4'hC};
    tb_v = '{4'h8, 4'h3, 4'h5, 4'h0, 4'h0, 4'h0, 4'hA, 4'hA, 4'hA};
    ts   = '{3'd0, 3'd1, 3'd1, 3'd6, 3'd7, 3'd5, 3'd2, 3'd3, 3'd4};
    te   = '{8'h91, 8'h30, 8'h4D, 8'h14, 8'h12, 8'h4F, 8'h00, 8'h00, 8'h00};
    for (int i = 6; i < 9; i++) te[i] = model(ta[i], tb_v[i], ts[i]);
    for (int i = 0; i < 9; i++) begin
      drive(ta[i], tb_v[i], ts[i], te[i]);
      @(posedge clk); #1;
      total++;
      if (bus.done !== 1'b1) begin bad++; $display("FAIL arith_done[%0d]: got %b want 1", i, bus.done); end
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL arith_queue[%0d]: scoreboard empty", i);
      end else begin
        e = exp_q.pop_front();
        if ({bus.flags, bus.result} !== e) begin
          bad++; $display("FAIL arith_op[%0d]: got flags=%b result=%h want flags=%b result=%h",
                          i, bus.flags, bus.result, e[7:4], e[3:0]);
        end
      end
    end
    bus.start = 1'b0;
    bus.a     = 4'h1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.done !== 1'b0 || {bus.flags, bus.result} !== te[8]) begin
        bad++; $display("FAIL arith_hold[%0d]: got done=%b fr=%h want 0/%h", i, bus.done,
                        {bus.flags, bus.result}, te[8]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] a, b;
    logic [2:0] s;
    logic [7:0] e;
    for (int i = 0; i < 3; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      s = 3'(i);
      drive(a, b, s, model(a, b, s));
      @(posedge clk); #1;
      total++;
      if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_done[%0d]: got %b want 1", i, bus.done); end
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL b2b_queue[%0d]: scoreboard empty", i);
      end else begin
        e = exp_q.pop_front();
        if ({bus.flags, bus.result} !== e) begin
          bad++; $display("FAIL b2b_op[%0d]: got %h want %h", i, {bus.flags, bus.result}, e);
        end
      end
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus.done !== 1'b0) begin bad++; $display("FAIL b2b_idle_done: got %b want 0", bus.done); end
  endtask

  task automatic test_scan;
    logic       pending;
    logic [7:0] e;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int         idx;
    bus.start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.an !== 4'b1110) begin bad++; $display("FAIL scan_reset_an: got %b want 1110", bus.an); end
    @(negedge clk) rst_n = 1'b1;
    drive(4'h3, 4'h4, 3'd0, 8'h07);
    pending = 1'b1;
    cur_res = 4'h0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      total++;
      if (bus.done !== pending) begin bad++; $display("FAIL scan_done[k=%0d]: got %b want %b", k, bus.done, pending); end
      if (pending) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL scan_queue[k=%0d]: scoreboard empty", k);
        end else begin
          e = exp_q.pop_front();
          cur_res = e[3:0];
          if ({bus.flags, bus.result} !== e) begin
            bad++; $display("FAIL scan_result[k=%0d]: got %h want %h", k, {bus.flags, bus.result}, e);
          end
        end
      end
      idx     = (k / SD) % D;
      exp_an  = ~(4'b0001 << idx);
      exp_seg = (idx == 0) ? glyph(cur_res) : 7'b1000000;
      total++;
      if (bus.an !== exp_an || bus.seg !== exp_seg) begin
        bad++; $display("FAIL scan_display[k=%0d]: got an=%b seg=%b want an=%b seg=%b",
                        k, bus.an, bus.seg, exp_an, exp_seg);
      end
      pending   = 1'b0;
      bus.start = 1'b0;
      if (k == 17) begin drive(4'hA, 4'h0, 3'd3, 8'h4A); pending = 1'b1; end
      if (k == 18) begin drive(4'h7, 4'h0, 3'd3, 8'h07); pending = 1'b1; end
    end
  endtask

  task automatic test_mid_dwell_reset;
    logic [3:0] exp_an;
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.result !== 4'h0) begin bad++; $display("FAIL mdr_result: got %h want 0", bus.result); end
    total++; if (bus.flags !== 4'h0) begin bad++; $display("FAIL mdr_flags: got %b want 0000", bus.flags); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL mdr_done: got %b want 0", bus.done); end
    total++; if (bus.an !== 4'b1110) begin bad++; $display("FAIL mdr_an: got %b want 1110", bus.an); end
    total++; if (bus.seg !== 7'b1000000) begin bad++; $display("FAIL mdr_seg: got %b want 1000000", bus.seg); end
    @(negedge clk) rst_n = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      @(posedge clk); #1;
      exp_an = ~(4'b0001 << ((j / SD) % D));
      total++;
      if (bus.an !== exp_an || bus.seg !== 7'b1000000) begin
        bad++; $display("FAIL mdr_dwell[j=%0d]: got an=%b seg=%b want an=%b seg=1000000",
                        j, bus.an, bus.seg, exp_an);
      end
    end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_back_to_back;
    test_scan;
    test_mid_dwell_reset;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/alu_scan_display.md
ALU_SCAN_DISPLAY -- requirements
Module: alu_scan_display

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the operand/result width in bits (legal 2..16).
REQ-002 The block SHALL have parameter DIGITS, default 4, meaning the number of multiplexed 7-segment digits (legal 1..8).
REQ-003 The block SHALL have parameter SCAN_DIV, default 100000, meaning clocks per digit dwell (legal >= 2).
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 sel  input  3  operation select.
REQ-009 start  input  1  capture request; a, b and sel are sampled on every clk edge where start=1.
REQ-010 result  output  WIDTH  registered ALU result.
REQ-011 flags  output  4  registered {V,N,Z,C}, bit 0 = C.
REQ-012 done  output  1  one-cycle pulse marking a new result/flags value.
REQ-013 an  output  DIGITS  digit enables, active-low, one-hot.
REQ-014 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-015 On a clk edge with start=1, result and flags SHALL load the operation of sel on a, b; latency 1 clock; done SHALL be 1 for exactly the following cycle.
REQ-016 When start=0, result and flags SHALL hold and done SHALL be 0; back-to-back start cycles SHALL each produce a done pulse and a new result.
REQ-017 sel: 000 a+b; 001 a-b; 010 a&b; 011 a|b; 100 a^b; 101 ~a; 110 a<<1; 111 a>>1 (logical); all truncated to WIDTH bits.
REQ-018 C: ADD = carry out of bit WIDTH-1; SUB = 1 when a >= b unsigned (no borrow); SHL = a[WIDTH-1]; SHR = a[0]; all others 0.
REQ-019 V: ADD/SUB = two's-complement signed overflow; all others 0.
REQ-020 N SHALL equal result bit WIDTH-1; Z SHALL be 1 when the WIDTH-bit result is 0.
REQ-021 A free-running scan counter SHALL count 0..SCAN_DIV-1 and wrap to 0; on the wrap cycle the digit index SHALL advance by 1 modulo DIGITS.
REQ-022 an SHALL drive low only bit [digit index]; transitions SHALL occur on the same edge as the index change (no blank cycle).
REQ-023 Display value SHALL be result zero-extended (or truncated) to 4*DIGITS bits; digit i SHALL show nibble i in hex.
REQ-024 seg SHALL decode 0-F to standard hex glyphs (0=1000000, 1=1111001, 8=0000000, F=0001110), registered so seg and an change on the same edge.
REQ-025 A start arriving mid-dwell SHALL update the displayed digit on the next clock without disturbing scan timing.

Reset
REQ-026 While rst_n=0, immediately and without a clock: result=0, flags=0000, done=0, scan counter=0, digit index=0, an = all ones except bit 0 low, seg=1000000.
REQ-027 After rst_n rises, the first start SHALL be honoured on the first clk edge; start coincident with rst_n=0 SHALL be ignored.
REQ-028 Reset asserted mid-dwell SHALL restart the scan at digit 0 with a full SCAN_DIV dwell.

Verification (WIDTH=4, DIGITS=4, SCAN_DIV=4)
REQ-029 start=1, sel=000, a=9, b=8 for one cycle -> next cycle result=1, flags V=1 N=0 Z=0 C=1, done=1 for one cycle only.
REQ-030 sel=001, a=3, b=3 -> result=0, Z=1, C=1, V=0; then a=2, b=5 -> result=D, C=0, N=1.
REQ-031 sel=110, a=A -> result=4, C=1; sel=111, a=5 -> result=2, C=1; sel=101, a=0 -> result=F, N=1.
REQ-032 Free run after reset -> an = 1110,1101,1011,0111, each held 4 clocks, then wraps to 1110; seg shows hex of nibble i (result=7 -> digit 0 seg=1111000, digits 1-3 seg=1000000).
REQ-033 Three consecutive start cycles with differing operands -> three done cycles, results follow one clock behind inputs.
REQ-034 rst_n pulsed low mid-dwell on digit 2 after result=7 -> outputs take REQ-026 values asynchronously; after release an=1110 held 4 full clocks.
